// File: rtl/drac_pkg.sv
// Shared pipeline types for the ID -> IR instruction queue path,
// including the state encoding of the queue head reader.
package drac_pkg;

   localparam int unsigned NUM_SCALAR_INSTR = 2;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [31:0] inst;
      logic        stall_csr_fence;
   } instr_entry_t;

   typedef struct packed {
      instr_entry_t instr;
   } id_ir_stage_t;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      SERIAL_WAIT = 2'd1,
      FLUSH       = 2'd2
   } iq_rd_state_t;

endpackage

// File: rtl/iq_head_reader.sv
// Instruction queue consumer: picks an in-order group of head entries, pops them,
// and registers the group for rename/issue; serializes CSR/fence and handles flushes.
module iq_head_reader
   import drac_pkg::*;
#(
   parameter int unsigned STALL_CNT_W = 32
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  id_ir_stage_t                  instruction_S_i [NUM_SCALAR_INSTR],
   input  logic                          empty_i,
   input  logic                          flush_i,
   input  logic                          ready_i,
   input  logic                          csr_fence_done_i,
   output logic [NUM_SCALAR_INSTR-1:0]   read_head_S_o,
   output id_ir_stage_t                  instruction_S_o [NUM_SCALAR_INSTR],
   output logic [NUM_SCALAR_INSTR-1:0]   valid_S_o,
   output logic                          serial_busy_o,
   output logic [STALL_CNT_W-1:0]        stall_cnt_o
);

   iq_rd_state_t                  state_q;
   id_ir_stage_t                  instr_q [NUM_SCALAR_INSTR];
   logic [NUM_SCALAR_INSTR-1:0]   valid_q;
   logic                          busy_q;
   logic [STALL_CNT_W-1:0]        stall_cnt_q;
   logic [STALL_CNT_W-1:0]        stall_cnt_d;
   logic                          load_s;
   logic [NUM_SCALAR_INSTR-1:0]   eligible_s;

   // A lane issues only behind eligible older lanes; a serializing entry only alone in lane 0.
   function automatic logic [NUM_SCALAR_INSTR-1:0] eligible_lanes(
      input logic         load,
      input logic         empty,
      input id_ir_stage_t lanes [NUM_SCALAR_INSTR]
   );
      logic                        chain;
      logic                        fence_seen;
      logic [NUM_SCALAR_INSTR-1:0] elig;
      chain      = load & ~empty;
      fence_seen = 1'b0;
      elig       = '0;
      for (int k = 0; k < NUM_SCALAR_INSTR; k++) begin
         chain      = chain & lanes[k].instr.valid & ~fence_seen
                      & ~((k != 0) & lanes[k].instr.stall_csr_fence);
         elig[k]    = chain;
         fence_seen = fence_seen | lanes[k].instr.stall_csr_fence;
      end
      return elig;
   endfunction

   // Load decision and lane selection; reset gating keeps pops quiet while in reset.
   always_comb begin
      load_s      = rstn_i && (state_q == RUN) && !flush_i && (!(|valid_q) || ready_i);
      eligible_s  = eligible_lanes(load_s, empty_i, instruction_S_i);
      if ((|valid_q) && !ready_i && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Reader FSM with the registered group, busy flag and stall counter.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= RUN;
         valid_q     <= '0;
         busy_q      <= 1'b0;
         stall_cnt_q <= '0;
         for (int k = 0; k < NUM_SCALAR_INSTR; k++) begin
            instr_q[k] <= '0;
         end
      end else begin
         stall_cnt_q <= stall_cnt_d;
         if (flush_i) begin
            valid_q <= '0;
            state_q <= FLUSH;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               RUN: begin
                  if (load_s) begin
                     valid_q <= eligible_s;
                     for (int k = 0; k < NUM_SCALAR_INSTR; k++) begin
                        if (eligible_s[k]) begin
                           instr_q[k] <= instruction_S_i[k];
                        end
                     end
                     if (eligible_s[0] && instruction_S_i[0].instr.stall_csr_fence) begin
                        state_q <= SERIAL_WAIT;
                        busy_q  <= 1'b1;
                     end
                  end else if (ready_i) begin
                     valid_q <= '0;
                  end
               end
               SERIAL_WAIT: begin
                  if (ready_i) begin
                     valid_q <= '0;
                  end
                  if (csr_fence_done_i) begin
                     state_q <= RUN;
                     busy_q  <= 1'b0;
                  end
               end
               FLUSH: begin
                  if (ready_i) begin
                     valid_q <= '0;
                  end
                  state_q <= RUN;
               end
               default: begin
                  state_q <= RUN;
                  valid_q <= '0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign read_head_S_o   = eligible_s;
   assign instruction_S_o = instr_q;
   assign valid_S_o       = valid_q;
   assign serial_busy_o   = busy_q;
   assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_iq_head_reader.sv
// Self-checking bench for iq_head_reader: directed vector table, saturation and
// reset sequences, then randomized traffic against a queue-level reference model.
module tb_iq_head_reader;
   import drac_pkg::*;

   localparam int CW = 4;

   logic                        clk = 1'b0;
   logic                        rstn, empty, flush, ready, done;
   id_ir_stage_t                lanes_in  [NUM_SCALAR_INSTR];
   id_ir_stage_t                lanes_out [NUM_SCALAR_INSTR];
   logic [NUM_SCALAR_INSTR-1:0] rh, vld;
   logic                        busy;
   logic [CW-1:0]               cnt;

   int checks = 0;
   int errors = 0;

   iq_head_reader #(.STALL_CNT_W(CW)) dut (
      .clk_i(clk), .rstn_i(rstn), .instruction_S_i(lanes_in), .empty_i(empty),
      .flush_i(flush), .ready_i(ready), .csr_fence_done_i(done),
      .read_head_S_o(rh), .instruction_S_o(lanes_out), .valid_S_o(vld),
      .serial_busy_o(busy), .stall_cnt_o(cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        empty, flush, ready, done;
      logic        v0, f0;
      logic [63:0] pc0;
      logic        v1, f1;
      logic [63:0] pc1;
      logic [1:0]  rh, vld;
      logic        busy;
      logic [3:0]  cnt;
      logic [63:0] opc0, opc1;
   } vec_t;

   vec_t tbl[$];

   function automatic id_ir_stage_t mk(input logic v, input logic f, input logic [63:0] pc);
      id_ir_stage_t e;
      e.instr.valid           = v;
      e.instr.stall_csr_fence = f;
      e.instr.pc              = pc;
      e.instr.inst            = pc[31:0] ^ 32'h0000_0013;
      return e;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add_row(input logic e, input logic fl, input logic r, input logic d,
                          input logic v0, input logic f0, input logic [63:0] pc0,
                          input logic v1, input logic f1, input logic [63:0] pc1,
                          input logic [1:0] xrh, input logic [1:0] xvld, input logic xbusy,
                          input logic [3:0] xcnt, input logic [63:0] o0, input logic [63:0] o1);
      vec_t t;
      t.empty = e;  t.flush = fl; t.ready = r;  t.done = d;
      t.v0 = v0;    t.f0 = f0;    t.pc0 = pc0;
      t.v1 = v1;    t.f1 = f1;    t.pc1 = pc1;
      t.rh = xrh;   t.vld = xvld; t.busy = xbusy; t.cnt = xcnt;
      t.opc0 = o0;  t.opc1 = o1;
      tbl.push_back(t);
   endtask

   // Reference model state
   localparam int M_RUN = 0, M_SERIAL = 1, M_FLUSH = 2;
   int           m_mode;
   logic [1:0]   m_vld;
   id_ir_stage_t m_out [NUM_SCALAR_INSTR];
   int           m_cnt;
   id_ir_stage_t q[$];

   initial begin
      rstn = 1'b0; empty = 1'b1; flush = 1'b0; ready = 1'b1; done = 1'b0;
      lanes_in[0] = '0; lanes_in[1] = '0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("reset_rh", rh, 2'b00);
      chk("reset_vld", vld, 2'b00);
      chk("reset_busy", busy, 1'b0);
      chk("reset_cnt", cnt, 4'd0);
      chk("reset_instr0", lanes_out[0], '0);
      chk("reset_instr1", lanes_out[1], '0);
      @(negedge clk);

      for (int i = 0; i < 4; i++)
         add_row(1,0,1,0, 0,0,64'h0, 0,0,64'h0, 2'b00,2'b00,0,4'd0, 64'h0,64'h0);
      add_row(1,0,1,0, 1,0,64'h50, 1,0,64'h54, 2'b00,2'b00,0,4'd0, 64'h0,64'h0);
      add_row(0,0,1,0, 1,0,64'h100, 1,0,64'h104, 2'b11,2'b11,0,4'd0, 64'h100,64'h104);
      add_row(0,0,1,0, 1,0,64'h108, 1,1,64'h10C, 2'b01,2'b01,0,4'd0, 64'h108,64'h104);
      add_row(0,0,1,0, 1,1,64'h10C, 1,0,64'h110, 2'b01,2'b01,1,4'd0, 64'h10C,64'h104);
      add_row(0,0,0,0, 1,0,64'h110, 1,0,64'h114, 2'b00,2'b01,1,4'd1, 64'h10C,64'h104);
      add_row(0,0,1,0, 1,0,64'h110, 1,0,64'h114, 2'b00,2'b00,1,4'd1, 64'h10C,64'h104);
      add_row(0,0,1,1, 1,0,64'h110, 1,0,64'h114, 2'b00,2'b00,0,4'd1, 64'h10C,64'h104);
      add_row(0,0,1,1, 1,0,64'h110, 1,0,64'h114, 2'b11,2'b11,0,4'd1, 64'h110,64'h114);
      for (int i = 0; i < 4; i++)
         add_row(0,0,0,0, 1,0,64'h118, 1,0,64'h11C, 2'b00,2'b11,0,4'(2+i), 64'h110,64'h114);
      add_row(0,0,1,0, 1,0,64'h118, 1,0,64'h11C, 2'b11,2'b11,0,4'd5, 64'h118,64'h11C);
      add_row(0,0,1,0, 1,1,64'h120, 1,0,64'h124, 2'b01,2'b01,1,4'd5, 64'h120,64'h11C);
      add_row(0,1,0,1, 1,0,64'h124, 1,0,64'h128, 2'b00,2'b00,0,4'd6, 64'h120,64'h11C);
      add_row(0,0,1,0, 1,0,64'h124, 1,0,64'h128, 2'b00,2'b00,0,4'd6, 64'h120,64'h11C);
      add_row(0,0,1,0, 1,0,64'h124, 1,0,64'h128, 2'b11,2'b11,0,4'd6, 64'h124,64'h128);
      add_row(0,1,1,0, 1,0,64'h12C, 1,0,64'h130, 2'b00,2'b00,0,4'd6, 64'h124,64'h128);
      add_row(0,1,0,0, 1,0,64'h12C, 1,0,64'h130, 2'b00,2'b00,0,4'd6, 64'h124,64'h128);
      add_row(0,0,1,0, 1,0,64'h12C, 1,0,64'h130, 2'b00,2'b00,0,4'd6, 64'h124,64'h128);
      add_row(0,0,1,0, 1,0,64'h12C, 1,0,64'h130, 2'b11,2'b11,0,4'd6, 64'h12C,64'h130);
      add_row(0,0,1,0, 1,0,64'h134, 0,0,64'h0,   2'b01,2'b01,0,4'd6, 64'h134,64'h130);
      add_row(0,0,1,0, 0,0,64'h0,   1,0,64'h138, 2'b00,2'b00,0,4'd6, 64'h134,64'h130);
      add_row(0,0,1,0, 1,0,64'h140, 1,0,64'h144, 2'b11,2'b11,0,4'd6, 64'h140,64'h144);

      for (int i = 0; i < tbl.size(); i++) begin
         empty = tbl[i].empty; flush = tbl[i].flush; ready = tbl[i].ready; done = tbl[i].done;
         lanes_in[0] = mk(tbl[i].v0, tbl[i].f0, tbl[i].pc0);
         lanes_in[1] = mk(tbl[i].v1, tbl[i].f1, tbl[i].pc1);
         #1;
         chk($sformatf("row%0d_rh", i), rh, tbl[i].rh);
         @(negedge clk);
         chk($sformatf("row%0d_vld", i), vld, tbl[i].vld);
         chk($sformatf("row%0d_busy", i), busy, tbl[i].busy);
         chk($sformatf("row%0d_cnt", i), cnt, tbl[i].cnt);
         chk($sformatf("row%0d_pc0", i), lanes_out[0].instr.pc, tbl[i].opc0);
         chk($sformatf("row%0d_pc1", i), lanes_out[1].instr.pc, tbl[i].opc1);
      end

      // Long backpressure: counter saturates at all-ones
      ready = 1'b0; done = 1'b0; flush = 1'b0; empty = 1'b0;
      lanes_in[0] = mk(1'b1, 1'b0, 64'h148);
      lanes_in[1] = mk(1'b1, 1'b0, 64'h14C);
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("sat_rh", rh, 2'b00);
         @(negedge clk);
         chk("sat_cnt", cnt, (6 + i + 1 > 15) ? 15 : 6 + i + 1);
         chk("sat_vld", vld, 2'b11);
      end

      // Reset with a pending group: group dropped, nothing popped
      rstn = 1'b0;
      ready = 1'b1;
      #1;
      chk("rst_mid_rh", rh, 2'b00);
      chk("rst_mid_vld", vld, 2'b00);
      chk("rst_mid_cnt", cnt, 4'd0);
      chk("rst_mid_pc0", lanes_out[0].instr.pc, 64'h0);
      @(negedge clk);
      chk("rst_hold_rh", rh, 2'b00);
      @(negedge clk);
      rstn = 1'b1;

      // Randomized traffic against the queue-level model
      m_mode = M_RUN; m_vld = 2'b00; m_cnt = 0;
      m_out[0] = '0; m_out[1] = '0;
      begin
         logic [63:0] next_pc;
         next_pc = 64'h1000;
         for (int cyc = 0; cyc < 400; cyc++) begin
            int   n;
            logic any_v, take;
            logic [1:0] exp_rh;
            while (q.size() < 4) begin
               q.push_back(mk(1'b1, $urandom_range(0, 99) < 15, next_pc));
               next_pc = next_pc + 64'd4;
            end
            flush = $urandom_range(0, 99) < 8;
            ready = $urandom_range(0, 99) < 70;
            done  = $urandom_range(0, 99) < 25;
            empty = $urandom_range(0, 99) < 10;
            lanes_in[0] = q[0];
            lanes_in[1] = q[1];

            any_v = (m_vld != 2'b00);
            take  = (m_mode == M_RUN) && !flush && (!any_v || ready) && !empty;
            n = 0;
            if (take) n = (q[0].instr.stall_csr_fence || q[1].instr.stall_csr_fence) ? 1 : 2;
            exp_rh = (n == 2) ? 2'b11 : ((n == 1) ? 2'b01 : 2'b00);
            #1;
            chk("rnd_rh", rh, exp_rh);

            if (any_v && !ready && m_cnt != 15) m_cnt++;
            if (flush) begin
               m_vld  = 2'b00;
               m_mode = M_FLUSH;
            end else if (m_mode == M_RUN && (!any_v || ready)) begin
               m_vld = 2'b00;
               for (int k = 0; k < n; k++) begin
                  m_out[k] = q[k];
                  m_vld[k] = 1'b1;
               end
               if (n > 0 && q[0].instr.stall_csr_fence) m_mode = M_SERIAL;
            end else begin
               if (ready) m_vld = 2'b00;
               if (m_mode == M_SERIAL && done) m_mode = M_RUN;
               else if (m_mode == M_FLUSH) m_mode = M_RUN;
            end
            for (int k = 0; k < n; k++) void'(q.pop_front());

            @(negedge clk);
            chk("rnd_vld", vld, m_vld);
            chk("rnd_out0", lanes_out[0], m_out[0]);
            chk("rnd_out1", lanes_out[1], m_out[1]);
            chk("rnd_busy", busy, m_mode == M_SERIAL);
            chk("rnd_cnt", cnt, m_cnt);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/iq_head_reader.md
# iq_head_reader

Consumer side of the instruction queue between ID and IR. Each cycle it peeks the queue head entries and selects an in-order group of up to NUM_SCALAR_INSTR instructions. It pulses read_head_S_o for each selected lane and registers the group for the rename/issue stage behind a ready handshake. It also serializes CSR/fence instructions and recovers from pipeline flushes.

## Interface
- NUM_SCALAR_INSTR, from drac_pkg (2): lanes per cycle.
- STALL_CNT_W, 32: width of the stall-cycle counter.
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- instruction_S_i  in  id_ir_stage_t[NUM_SCALAR_INSTR]  queue head entries; lane 0 is oldest.
- empty_i  in  1  queue empty.
- flush_i  in  1  pipeline flush.
- ready_i  in  1  downstream accepts the whole registered group this cycle.
- csr_fence_done_i  in  1  commit has retired the outstanding serializing instruction.
- read_head_S_o  out  1[NUM_SCALAR_INSTR]  pop request per lane.
- instruction_S_o  out  id_ir_stage_t[NUM_SCALAR_INSTR]  registered group.
- valid_S_o  out  1[NUM_SCALAR_INSTR]  per-lane valid of the registered group.
- serial_busy_o  out  1  state is SERIAL_WAIT.
- stall_cnt_o  out  STALL_CNT_W  saturating count of backpressured cycles.

## Operation
- States: RUN, SERIAL_WAIT, FLUSH. Reset state is RUN.
- load = state==RUN && !flush_i && (no valid_S_o set || ready_i).
- Lane k is eligible when all of these hold:
  - load, !empty_i, and instruction_S_i[k].instr.valid.
  - All lanes j<k are eligible.
  - No lane j<k carries instr.stall_csr_fence.
  - If k>0, lane k itself does not carry stall_csr_fence.
- A serializing instruction therefore issues only in lane 0 and alone.
- read_head_S_o[k] = eligible[k]. On a load, instruction_S_o and valid_S_o take the eligible lanes; ineligible lanes get valid 0 and hold their old data.
- If ready_i && !load, all valid_S_o clear.
- A loaded lane 0 with stall_csr_fence moves RUN to SERIAL_WAIT.
- SERIAL_WAIT: no reads. The registered group still drains via ready_i. csr_fence_done_i moves to RUN.
- flush_i, from any state, takes priority over everything:
  - read_head_S_o is all 0 that cycle.
  - Next cycle: valid_S_o all 0, state FLUSH.
  - FLUSH lasts exactly one cycle with no reads, then RUN, unless flush_i is still asserted, which keeps FLUSH.
- stall_cnt_o increments when any valid_S_o is set && !ready_i. It saturates at all-ones. Flush does not clear it.
- csr_fence_done_i outside SERIAL_WAIT is ignored.

## Timing
- read_head_S_o is combinational from inputs and state, in the same cycle as the capture.
- The registered group appears on instruction_S_o/valid_S_o one cycle after its read_head_S_o pulse.
- Throughput is one group per cycle while ready_i stays high.
- Reset values:
  - valid_S_o and read_head_S_o are 0.
  - instruction_S_o is all 0.
  - stall_cnt_o is 0; serial_busy_o is 0; state is RUN.
- Reset mid-group discards the group with no pop.
- Simultaneous events:
  - flush_i with ready_i: flush wins and no new load occurs.
  - flush_i with csr_fence_done_i: go to FLUSH.
  - empty_i with a valid entry: no read.

## Structure
- From drac_pkg: id_ir_stage_t and NUM_SCALAR_INSTR.
- Add iq_rd_state_t (RUN, SERIAL_WAIT, FLUSH) to drac_pkg.
- Single module. The eligibility prefix chain is a local function; no sub-module.

## Test plan
- Reset, then idle with empty_i=1: read_head_S_o=00, valid_S_o=00, stall_cnt_o=0 for 5 cycles.
- Two valid plain instructions, PC 0x100/0x104, ready_i=1: read_head_S_o=11 in cycle N; cycle N+1 valid_S_o=11 with those PCs.
- Lane 0 plain, lane 1 CSR:
  - Cycle N: read_head=01.
  - Next cycle with the CSR in lane 0: read_head=01, then serial_busy_o=1 and no reads.
  - csr_fence_done_i pulse: RUN next cycle and reads resume.
- ready_i=0 for 4 cycles with a valid group: read_head=00 throughout, output data stable, stall_cnt_o rises by 4.
- flush_i during SERIAL_WAIT with valid output:
  - Next cycle: valid_S_o=00, state FLUSH, no reads.
  - Following cycle: RUN, and reads resume if the queue is non-empty.
- Force stall_cnt_o near max (STALL_CNT_W=4, 20 stall cycles): holds at 15.
